// File: rtl/cpu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, WIDTH cycles per op.
// Optional MULDIV_EARLY_OUT_EN: trivial ops (div by zero, signed overflow, multiply by zero) skip RUN.
module cpu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             I_clk,
    input  logic             I_reset_n,
    input  logic             I_stb,
    input  logic [2:0]       I_op,
    input  logic [WIDTH-1:0] I_a,
    input  logic [WIDTH-1:0] I_b,
    output logic             O_busy,
    output logic             O_ready,
    output logic [WIDTH-1:0] O_result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               special_q, special_d;
    logic [WIDTH-1:0]   special_val_q, special_val_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    // operand decode
    logic               in_is_div, in_is_rem;
    logic               in_a_signed, in_b_signed;
    logic               in_a_neg, in_b_neg;
    logic [WIDTH-1:0]   in_a_mag, in_b_mag;
    logic               in_div_zero, in_div_ovf, in_mul_zero, in_skip;

    // iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_diff;

    // fix-up datapath
    logic               res_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_result;

    always_comb begin
        in_is_div   = I_op[2];
        in_is_rem   = I_op[2] & I_op[1];
        in_a_signed = (I_op == OP_MULH) || (I_op == OP_MULHSU) ||
                      (I_op == OP_DIV)  || (I_op == OP_REM);
        in_b_signed = (I_op == OP_MULH) || (I_op == OP_DIV) || (I_op == OP_REM);
        in_a_neg    = in_a_signed & I_a[WIDTH-1];
        in_b_neg    = in_b_signed & I_b[WIDTH-1];
        in_a_mag    = in_a_neg ? (~I_a + 1'b1) : I_a;
        in_b_mag    = in_b_neg ? (~I_b + 1'b1) : I_b;
        in_div_zero = in_is_div && (I_b == '0);
        in_div_ovf  = ((I_op == OP_DIV) || (I_op == OP_REM)) &&
                      (I_a == {1'b1, {(WIDTH-1){1'b0}}}) && (I_b == '1);
        in_mul_zero = !in_is_div && ((I_a == '0) || (I_b == '0));
`ifdef MULDIV_EARLY_OUT_EN
        in_skip     = in_div_zero | in_div_ovf | in_mul_zero;
`else
        in_skip     = 1'b0;
`endif
    end

    always_comb begin
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff    = div_shifted - {1'b0, opnd_q};
    end

    // The accumulator holds {remainder, quotient} for divides and {high, low} for multiplies.
    always_comb begin
        res_neg  = sign_a_q ^ sign_b_q;
        prod_fix = res_neg ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = res_neg ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
        if (special_q) begin
            fix_result = special_val_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        cnt_d         = cnt_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        result_d      = result_q;
        busy_d        = busy_q;
        ready_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (I_stb) begin
                    op_d      = I_op;
                    sign_a_d  = in_a_neg;
                    sign_b_d  = in_b_neg;
                    opnd_d    = in_is_div ? in_b_mag : in_a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (in_is_div ? in_a_mag : in_b_mag)};
                    cnt_d     = '0;
                    special_d = in_div_zero | in_div_ovf | in_mul_zero;
                    if (in_div_zero) begin
                        special_val_d = in_is_rem ? I_a : '1;
                    end else if (in_div_ovf) begin
                        special_val_d = in_is_rem ? '0 : I_a;
                    end else begin
                        special_val_d = '0;
                    end
                    busy_d  = 1'b1;
                    state_d = in_skip ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (op_q[2]) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_result;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            acc_q         <= '0;
            opnd_q        <= '0;
            cnt_q         <= '0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            cnt_q         <= cnt_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            result_q      <= result_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
        end
    end

    assign O_busy   = busy_q;
    assign O_ready  = ready_q;
    assign O_result = result_q;

endmodule
